// File: rtl/shift6_pkg.sv
// Shared types and sizes for the 6-bit serial transmit sequencer.
// The optional parity slot is enabled by defining SHIFT6_TX_PARITY_EN.
package shift6_pkg;

  localparam int unsigned DATA_W        = 6;
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned TICK_CNT_W    = 4;
  localparam int unsigned BIT_TICKS_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CORE_HOLD,
    CORE_LOAD,
    CORE_SHL,
    CORE_SHR
  } core_op_t;

endpackage

// File: rtl/shift6_core.sv
// 6-bit data register with load / shift-left / shift-right / hold and zero-fill.
// Also reports which bit will sit at the serial head after a load or a shift.
module shift6_core
  import shift6_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              msb_first,
  input  core_op_t          op,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_head_c,
  output logic              shift_head_c
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (op)
        CORE_LOAD: q <= load_data;
        CORE_SHL:  q <= {q[DATA_W-2:0], 1'b0};
        CORE_SHR:  q <= {1'b0, q[DATA_W-1:1]};
        default:   q <= q;
      endcase
    end
  end

  assign load_head_c  = msb_first ? load_data[DATA_W-1] : load_data[0];
  assign shift_head_c = msb_first ? q[DATA_W-2] : q[1];

endmodule

// File: rtl/shift6_tx_sequencer.sv
// Sequences a 6-bit word from a valid/ready input out as a paced serial stream.
// Define SHIFT6_TX_PARITY_EN to append an even-parity bit slot after the data bits.
module shift6_tx_sequencer
  import shift6_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned BIT_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              ser_out,
  output logic              ser_en,
  output logic              busy,
  output logic              done
);

  generate
    if (BIT_TICKS == 0 || BIT_TICKS > BIT_TICKS_MAX) begin : g_bad_bit_ticks
      $error("BIT_TICKS must be in 1..16");
    end
  endgenerate

  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(BIT_TICKS - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_W - 1);
  localparam core_op_t              SHIFT_OP  = (MSB_FIRST != 0) ? CORE_SHL : CORE_SHR;

  state_t                state, state_n;
  logic [TICK_CNT_W-1:0] tick_cnt, tick_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_n;
  core_op_t              op;
  logic                  ser_out_n;
  logic                  load_head_c, shift_head_c;
  logic                  tick_last_c;

  shift6_core u_core (
    .clk          (clk),
    .rst          (rst),
    .msb_first    (MSB_FIRST != 0),
    .op           (op),
    .load_data    (in_data),
    .load_head_c  (load_head_c),
    .shift_head_c (shift_head_c)
  );

`ifdef SHIFT6_TX_PARITY_EN
  logic parity;

  // Parity of the word as captured at accept.
  always_ff @(posedge clk) begin
    if (rst)                    parity <= 1'b0;
    else if (op == CORE_LOAD)   parity <= ^in_data;
  end
`endif

  assign tick_last_c = (tick_cnt == TICK_LAST);
  assign in_ready    = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
    end
  end

  // Next state, counters, register control and next serial bit; abort wins over advancing.
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    op        = CORE_HOLD;
    ser_out_n = ser_out;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n   = SHIFT;
          tick_n    = '0;
          bit_n     = '0;
          op        = CORE_LOAD;
          ser_out_n = load_head_c;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n   = IDLE;
          tick_n    = '0;
          bit_n     = '0;
          ser_out_n = 1'b0;
        end else if (tick_last_c) begin
          tick_n = '0;
          op     = SHIFT_OP;
          if (bit_cnt == BIT_LAST) begin
`ifdef SHIFT6_TX_PARITY_EN
            state_n   = PAR;
            ser_out_n = parity;
`else
            state_n   = DONE;
            ser_out_n = 1'b0;
`endif
          end else begin
            bit_n     = bit_cnt + BIT_CNT_W'(1);
            ser_out_n = shift_head_c;
          end
        end else begin
          tick_n = tick_cnt + TICK_CNT_W'(1);
        end
      end
`ifdef SHIFT6_TX_PARITY_EN
      PAR: begin
        if (abort) begin
          state_n   = IDLE;
          tick_n    = '0;
          bit_n     = '0;
          ser_out_n = 1'b0;
        end else if (tick_last_c) begin
          state_n   = DONE;
          tick_n    = '0;
          ser_out_n = 1'b0;
        end else begin
          tick_n = tick_cnt + TICK_CNT_W'(1);
        end
      end
`endif
      DONE: begin
        state_n   = IDLE;
        ser_out_n = 1'b0;
      end
      default: begin
        state_n   = IDLE;
        ser_out_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_out <= ser_out_n;
      ser_en  <= (state_n == SHIFT) || (state_n == PAR);
      busy    <= (state_n == SHIFT) || (state_n == PAR);
      done    <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_shift6_tx_sequencer.sv
// Randomized bench for shift6_tx_sequencer against a frame-timing reference model.
// Three instances cover MSB/LSB first and BIT_TICKS of 1 and 3; honours SHIFT6_TX_PARITY_EN.
module tb_shift6_tx_sequencer;

  localparam int NI = 3;
  localparam int MSBV [NI] = '{1, 0, 1};
  localparam int BTV  [NI] = '{1, 1, 3};
`ifdef SHIFT6_TX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] in_data = '0;
  logic       rdy [NI];
  logic       so  [NI];
  logic       se  [NI];
  logic       bz  [NI];
  logic       dn  [NI];

  always #5 clk = ~clk;

  shift6_tx_sequencer #(.MSB_FIRST(1), .BIT_TICKS(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .abort(abort), .ser_out(so[0]), .ser_en(se[0]), .busy(bz[0]), .done(dn[0]));
  shift6_tx_sequencer #(.MSB_FIRST(0), .BIT_TICKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .abort(abort), .ser_out(so[1]), .ser_en(se[1]), .busy(bz[1]), .done(dn[1]));
  shift6_tx_sequencer #(.MSB_FIRST(1), .BIT_TICKS(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .abort(abort), .ser_out(so[2]), .ser_en(se[2]), .busy(bz[2]), .done(dn[2]));

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  bit         check_en = 1'b0;
  int         edge_n = 0;
  bit         act [NI];
  int         st  [NI];
  logic [5:0] wd  [NI];
  int         rp;
  bit         idle;

  // Model: each instance either has no frame, or a frame accepted at edge st[i] with word wd[i].
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < NI; i++) begin
      rp   = edge_n - 1 - st[i];
      idle = !act[i] || (rp > NB * BTV[i]);
      if (rst) act[i] = 1'b0;
      else if (act[i] && rp < NB * BTV[i] && abort) act[i] = 1'b0;
      else if (idle && in_valid) begin
        act[i] = 1'b1;
        st[i]  = edge_n;
        wd[i]  = in_data;
      end
    end
  end

  // Expected {ser_out, ser_en, busy, done, in_ready} in the cycle after edge edge_n.
  function automatic logic [4:0] model_out(input int i, input logic r);
    int   rel, len, k;
    logic b;
    len = NB * BTV[i];
    if (!act[i]) return {4'b0000, !r};
    rel = edge_n - st[i];
    if (rel < len) begin
      k = rel / BTV[i];
      if (k >= 6) b = ^wd[i];
      else if (MSBV[i] != 0) b = wd[i][5-k];
      else b = wd[i][k];
      return {b, 4'b1100};
    end
    if (rel == len) return 5'b00010;
    return {4'b0000, !r};
  endfunction

  always @(negedge clk) begin
    logic [4:0] got, exp;
    if (check_en) begin
      for (int i = 0; i < NI; i++) begin
        got = {so[i], se[i], bz[i], dn[i], rdy[i]};
        exp = model_out(i, rst);
        cmp_cnt = cmp_cnt + 1;
        if (got !== exp) begin
          err_cnt = err_cnt + 1;
          $display("FAIL model inst%0d edge%0d: so/se/busy/done/rdy got %b expected %b",
                   i, edge_n, got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    cmp_cnt = cmp_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Present one word so it is accepted at the next edge, then withdraw it.
  task automatic accept(input logic [5:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #2 in_valid = 1'b0;
  endtask

  bit exp_msb [6] = '{1, 1, 0, 0, 1, 0};
  bit exp_lsb [6] = '{0, 1, 0, 0, 1, 1};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", rdy[0], 1'b0);
    chk("reset ser_en", se[0], 1'b0);
    chk("reset done", dn[0], 1'b0);
    check_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", rdy[0], 1'b1);

    // 6'b110010, BIT_TICKS=1, both bit orders.
    accept(6'b110010);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("msb-first bit", so[0], exp_msb[k]);
      chk("lsb-first bit", so[1], exp_lsb[k]);
    end
`ifdef SHIFT6_TX_PARITY_EN
    @(negedge clk);
    chk("parity bit", so[0], 1'b1);
    chk("parity ser_en", se[0], 1'b1);
`endif
    @(negedge clk);
    chk("done pulse", dn[0], 1'b1);
    @(negedge clk);
    chk("in_ready after done", rdy[0], 1'b1);
    chk("done one cycle", dn[0], 1'b0);

    // BIT_TICKS=3, single leading one.
    repeat (30) @(negedge clk);
    accept(6'b100000);
    for (int c = 1; c <= NB * 3; c++) begin
      @(negedge clk);
      chk("bt3 ser_out", so[2], (c <= 3) || (c > 18));
    end
    @(negedge clk);
    chk("bt3 done", dn[2], 1'b1);

    // in_valid held high with a fresh word every cycle.
    repeat (30) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'($urandom);
    @(posedge clk);
    for (int c = 1; c <= NB + 1; c++) begin
      @(negedge clk);
      chk("b2b in_ready low", rdy[0], 1'b0);
      in_data = 6'($urandom);
    end
    @(negedge clk);
    chk("b2b in_ready high", rdy[0], 1'b1);
    @(posedge clk);
    #2 in_valid = 1'b0;

    // abort during bit 2.
    repeat (40) @(negedge clk);
    accept(6'b101101);
    @(posedge clk);
    @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    chk("abort ser_en", se[0], 1'b0);
    chk("abort busy", bz[0], 1'b0);
    chk("abort in_ready", rdy[0], 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort no done", dn[0], 1'b0);
    end

    // rst mid-word.
    repeat (20) @(negedge clk);
    accept(6'b111111);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst ser_out", so[0], 1'b0);
    chk("rst ser_en", se[0], 1'b0);
    chk("rst busy", bz[0], 1'b0);
    chk("rst in_ready", rdy[0], 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst release in_ready", rdy[0], 1'b1);
    chk("rst no done", dn[0], 1'b0);

    // Random traffic with occasional abort and reset.
    repeat (3000) begin
      @(posedge clk);
      #2;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 6'($urandom);
      abort    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
